// File: rtl/harmonic_ladder_generator.sv
// rtl/harmonic_ladder_generator.sv - geometric five-band omega ladder with bounded-rate slewing
// Optional feature macro: HARMONIC_ROUND_EN (round half up on each ladder product instead of truncating)
module harmonic_ladder_generator #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int SLEW_STEP = 4,
  parameter int MIN_OMEGA = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic signed [WIDTH-1:0] cfg_base,
  input  logic signed [WIDTH-1:0] cfg_ratio,
  output logic signed [WIDTH-1:0] omega_theta,
  output logic signed [WIDTH-1:0] omega_alpha,
  output logic signed [WIDTH-1:0] omega_beta1,
  output logic signed [WIDTH-1:0] omega_beta2,
  output logic signed [WIDTH-1:0] omega_gamma,
  output logic                    busy,
  output logic                    settled
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SLEW = 2'd2;

  localparam logic signed [WIDTH-1:0]   OMEGA_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   OMEGA_MIN = WIDTH'(MIN_OMEGA);
  localparam logic signed [WIDTH-1:0]   RATIO_ONE = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0]   RATIO_PHI = WIDTH'(26510);
  localparam logic signed [WIDTH:0]     STEP_WIDE = (WIDTH+1)'(SLEW_STEP);
  localparam logic signed [WIDTH-1:0]   STEP_NARROW = WIDTH'(SLEW_STEP);
  localparam logic signed [2*WIDTH-1:0] SAT_WIDE = {{WIDTH{1'b0}}, OMEGA_MAX};

  // Power-up ladder: a golden-ratio spread starting at 152
  function automatic logic signed [WIDTH-1:0] reset_omega(input int idx);
    case (idx)
      0:       return WIDTH'(152);
      1:       return WIDTH'(245);
      2:       return WIDTH'(397);
      3:       return WIDTH'(642);
      default: return WIDTH'(1040);
    endcase
  endfunction

  logic [1:0]              state;
  logic [2:0]              calc_idx;
  logic signed [WIDTH-1:0] ratio_q;
  logic signed [WIDTH-1:0] omega  [5];
  logic signed [WIDTH-1:0] target [5];

  logic                      accept;
  logic signed [WIDTH-1:0]   base_clamped;
  logic signed [WIDTH-1:0]   ratio_fixed;
  logic signed [WIDTH-1:0]   calc_src;
  logic signed [2*WIDTH-1:0] product;
  logic signed [2*WIDTH-1:0] scaled;
  logic signed [WIDTH-1:0]   calc_result;
  logic signed [WIDTH-1:0]   omega_next [5];
  logic                      all_at_target;

  assign cfg_ready = (state != S_CALC);
  assign busy      = (state == S_CALC);
  assign accept    = cfg_valid && cfg_ready;

  assign omega_theta = omega[0];
  assign omega_alpha = omega[1];
  assign omega_beta1 = omega[2];
  assign omega_beta2 = omega[3];
  assign omega_gamma = omega[4];

  // Sanitise an incoming configuration: keep the base positive and the ratio expanding
  always_comb begin
    base_clamped = cfg_base;
    if (cfg_base < OMEGA_MIN) begin
      base_clamped = OMEGA_MIN;
    end
    ratio_fixed = cfg_ratio;
    if (cfg_ratio < RATIO_ONE) begin
      ratio_fixed = RATIO_PHI;
    end
  end

  // One ladder rung per clock: previous target times ratio, back to integer, saturated
  always_comb begin
    calc_src = target[calc_idx];
    product  = $signed({{WIDTH{calc_src[WIDTH-1]}}, calc_src}) *
               $signed({{WIDTH{ratio_q[WIDTH-1]}}, ratio_q});
`ifdef HARMONIC_ROUND_EN
    product  = product + $signed({{(2*WIDTH-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
`endif
    scaled   = product >>> FRAC;
    if (scaled > SAT_WIDE) begin
      calc_result = OMEGA_MAX;
    end else if (scaled < 0) begin
      calc_result = '0;
    end else begin
      calc_result = scaled[WIDTH-1:0];
    end
  end

  // Bounded step of every output toward its target, plus the all-arrived flag
  always_comb begin
    all_at_target = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic signed [WIDTH:0] diff;
      diff = {target[i][WIDTH-1], target[i]} - {omega[i][WIDTH-1], omega[i]};
      if (diff > STEP_WIDE) begin
        omega_next[i] = omega[i] + STEP_NARROW;
      end else if (diff < -STEP_WIDE) begin
        omega_next[i] = omega[i] - STEP_NARROW;
      end else begin
        omega_next[i] = target[i];
      end
      if (omega_next[i] != target[i]) begin
        all_at_target = 1'b0;
      end
    end
  end

  // Control FSM: accept -> CALC (4 rungs) -> SLEW until every output reaches its target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      settled  <= 1'b1;
      calc_idx <= 3'd0;
      ratio_q  <= RATIO_PHI;
      for (int i = 0; i < 5; i++) begin
        omega[i]  <= reset_omega(i);
        target[i] <= reset_omega(i);
      end
    end else if (accept) begin
      target[0] <= base_clamped;
      ratio_q   <= ratio_fixed;
      calc_idx  <= 3'd0;
      state     <= S_CALC;
      settled   <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          target[calc_idx + 3'd1] <= calc_result;
          if (calc_idx == 3'd3) begin
            state <= S_SLEW;
          end else begin
            calc_idx <= calc_idx + 3'd1;
          end
        end
        S_SLEW: begin
          if (clk_en) begin
            for (int i = 0; i < 5; i++) begin
              omega[i] <= omega_next[i];
            end
            if (all_at_target) begin
              settled <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_ladder_generator.sv
// tb/tb_harmonic_ladder_generator.sv - scoreboard bench for harmonic_ladder_generator
module tb_harmonic_ladder_generator;

  localparam int W = 18;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clk_en = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic signed [W-1:0] cfg_base = '0;
  logic signed [W-1:0] cfg_ratio = '0;
  logic signed [W-1:0] omega_theta, omega_alpha, omega_beta1, omega_beta2, omega_gamma;
  logic                busy, settled;

  harmonic_ladder_generator dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_ratio(cfg_ratio),
    .omega_theta(omega_theta), .omega_alpha(omega_alpha), .omega_beta1(omega_beta1),
    .omega_beta2(omega_beta2), .omega_gamma(omega_gamma),
    .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    v[5];
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input string tag, input int a, input int b, input int c, input int d, input int e);
    exp_t x;
    x.tag = tag;
    x.v[0] = a; x.v[1] = b; x.v[2] = c; x.v[3] = d; x.v[4] = e;
    exp_q.push_back(x);
  endtask

  task automatic check_outs(input string tag, input int a, input int b, input int c, input int d, input int e);
    chk({tag, "_theta"}, int'(omega_theta), a);
    chk({tag, "_alpha"}, int'(omega_alpha), b);
    chk({tag, "_beta1"}, int'(omega_beta1), c);
    chk({tag, "_beta2"}, int'(omega_beta2), d);
    chk({tag, "_gamma"}, int'(omega_gamma), e);
  endtask

  // Monitor: slew-rate / clk_en-gating checks on every change, scoreboard pop on each settle
  logic en_at_edge = 1'b0;
  always @(posedge clk) en_at_edge = clk_en;

  int cur[5];
  int prev[5];
  bit have_prev = 0;
  bit prev_settled = 1;

  always @(negedge clk) begin
    cur[0] = int'(omega_theta); cur[1] = int'(omega_alpha); cur[2] = int'(omega_beta1);
    cur[3] = int'(omega_beta2); cur[4] = int'(omega_gamma);
    if (!rst_n) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        for (int i = 0; i < 5; i++) begin
          if (cur[i] != prev[i]) begin
            checks++;
            if (cur[i] - prev[i] > 4 || prev[i] - cur[i] > 4 || !en_at_edge || cur[i] < 0) begin
              errors++;
              $display("FAIL slew_step[%0d]: got %0d -> %0d (clk_en=%0b) required |step|<=4 on clk_en, non-negative",
                       i, prev[i], cur[i], en_at_edge);
            end
          end
        end
        if (settled && !prev_settled) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_settle", 1, 0);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
              chk($sformatf("%s_settled[%0d]", x.tag, i), cur[i], x.v[i]);
            end
          end
        end
      end
      prev = cur;
      prev_settled = settled;
      have_prev = 1;
    end
  end

  task automatic load(input int base, input int ratio);
    int n, bc, rc;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_wait", int'(cfg_ready), 1);
    cfg_base  = W'(base);
    cfg_ratio = W'(ratio);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    bc = 0; rc = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) bc++;
      if (!cfg_ready) rc++;
    end
    chk("busy_cycles", bc, 4);
    chk("ready_low_cycles", rc, 4);
  endtask

  task automatic tick();
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
  endtask

  task automatic run_until_settled(input int bound, input string tag);
    int n;
    n = 0;
    while (!settled && n < bound) begin
      tick();
      n++;
    end
    chk(tag, int'(settled), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_outs(tag, 152, 245, 397, 642, 1040);
    chk({tag, "_ready"}, int'(cfg_ready), 1);
    chk({tag, "_settled"}, int'(settled), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic push_nominal(input string tag);
`ifdef HARMONIC_ROUND_EN
    push_exp(tag, 152, 246, 398, 644, 1042);
`else
    push_exp(tag, 152, 245, 396, 640, 1035);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal load and tick-by-tick slew
    push_nominal("nominal");
    load(152, 26510);
    tick();
`ifdef HARMONIC_ROUND_EN
    check_outs("tick1", 152, 246, 398, 644, 1042);
    chk("tick1_settled", int'(settled), 1);
`else
    check_outs("tick1", 152, 245, 396, 640, 1036);
    chk("tick1_settled", int'(settled), 0);
    tick();
    check_outs("tick2", 152, 245, 396, 640, 1035);
    chk("tick2_settled", int'(settled), 1);
`endif

    // Asynchronous reset mid-cycle, observed before any clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Preemption during SLEW
    load(300, 26510);
    tick();
    tick();
    chk("preempt_theta_mid", int'(omega_theta), 160);
    push_nominal("preempt");
    load(152, 26510);
    chk("preempt_theta_hold", int'(omega_theta), 160);
    run_until_settled(100, "preempt_settle");

    // Base clamp and ratio substitution
`ifdef HARMONIC_ROUND_EN
    push_exp("clamp", 10, 16, 26, 42, 68);
`else
    push_exp("clamp", 10, 16, 25, 40, 64);
`endif
    load(3, 8192);
    run_until_settled(400, "clamp_settle");

    // Reset two cycles into CALC, then a normal load
    cfg_base  = W'(152);
    cfg_ratio = W'(26510);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 chk("midcalc_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1 check_reset_state("midcalc_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_nominal("after_rst");
    load(152, 26510);
    run_until_settled(20, "after_rst_settle");

    // Saturation at the top of the range
    push_exp("saturate", 100000, 131071, 131071, 131071, 131071);
    load(100000, 32768);
    run_until_settled(40000, "saturate_settle");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
